// File: rtl/edm_tx_framer.sv
// edm_tx_framer: drains a fall-through 64-bit FIFO into a START/DATA/TERM/IDLE block stream.
// Optional feature macro EDM_TX_IPG_EN: enforces IPG_BLOCKS IDLE blocks between TERM and the next START.
module edm_tx_framer #(
    parameter int MAX_BURST  = 16,
    parameter int IPG_BLOCKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [63:0] fifo_rdata,
    output logic        fifo_rd,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [1:0]  tx_hdr,
    output logic [63:0] tx_data,
    output logic        busy
);

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;
    localparam logic [7:0] MAX_C    = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TERM = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_IDLE  = 2'd0,
        K_START = 2'd1,
        K_DATA  = 2'd2,
        K_TERM  = 2'd3
    } kind_t;

    function automatic logic [63:0] idle_block();
        return {56'h0, 8'h1E};
    endfunction

    function automatic logic [63:0] start_block(input logic [7:0] seq);
        return {48'h0, seq, 8'h78};
    endfunction

    function automatic logic [63:0] term_block(input logic [7:0] cnt, input logic [7:0] seq);
        return {40'h0, seq, cnt, 8'h87};
    endfunction

    if ((MAX_BURST < 1) || (MAX_BURST > 255) || (IPG_BLOCKS < 1) || (IPG_BLOCKS > 15)) begin : g_param_range
        $error("edm_tx_framer: MAX_BURST or IPG_BLOCKS out of range");
    end

    state_t      state_r, state_next_s;
    kind_t       kind_s;
    logic [7:0]  seq_r, seq_next_s;
    logic [7:0]  cnt_r, cnt_next_s;
    logic [63:0] blk_data_s;
    logic        fifo_rd_s;
    logic        start_ok_s;
    logic        busy_next_s;
    logic        tx_valid_r;
    logic [1:0]  tx_hdr_r;
    logic [63:0] tx_data_r;
    logic        busy_r;

`ifdef EDM_TX_IPG_EN
    localparam logic [3:0] IPG_C = 4'(IPG_BLOCKS);
    logic [3:0] ipg_r, ipg_next_s;

    // Gap counter: reload on every TERM, count down on IDLE blocks actually sent
    always_comb begin
        ipg_next_s = ipg_r;
        if (tx_ready && (kind_s == K_TERM)) begin
            ipg_next_s = IPG_C;
        end else if (tx_ready && (kind_s == K_IDLE) && (ipg_r != 4'd0)) begin
            ipg_next_s = ipg_r - 4'd1;
        end else begin
            ipg_next_s = ipg_r;
        end
    end

    // Gap counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ipg_r <= 4'd0;
        end else begin
            ipg_r <= ipg_next_s;
        end
    end

    assign start_ok_s  = (ipg_r == 4'd0);
    assign busy_next_s = (state_next_s != ST_IDLE) || (ipg_next_s != 4'd0);
`else
    assign start_ok_s  = 1'b1;
    assign busy_next_s = (state_next_s != ST_IDLE);
`endif

    // Next-state, counters and block selection; everything holds on a stalled slot
    always_comb begin
        state_next_s = state_r;
        seq_next_s   = seq_r;
        cnt_next_s   = cnt_r;
        kind_s       = K_IDLE;
        fifo_rd_s    = 1'b0;
        if (tx_ready) begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty && start_ok_s) begin
                        kind_s       = K_START;
                        cnt_next_s   = 8'd0;
                        state_next_s = ST_DATA;
                    end else begin
                        kind_s       = K_IDLE;
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!fifo_empty && (cnt_r < MAX_C)) begin
                        kind_s     = K_DATA;
                        fifo_rd_s  = 1'b1;
                        cnt_next_s = cnt_r + 8'd1;
                        if ((cnt_r + 8'd1) == MAX_C) begin
                            state_next_s = ST_TERM;
                        end else begin
                            state_next_s = ST_DATA;
                        end
                    end else begin
                        // FIFO ran dry: close the burst with whatever count was reached
                        kind_s       = K_TERM;
                        seq_next_s   = seq_r + 8'd1;
                        state_next_s = ST_IDLE;
                    end
                end
                ST_TERM: begin
                    kind_s       = K_TERM;
                    seq_next_s   = seq_r + 8'd1;
                    state_next_s = ST_IDLE;
                end
                default: begin
                    kind_s       = K_IDLE;
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            kind_s       = K_IDLE;
            state_next_s = state_r;
        end
    end

    // Payload for the selected block
    always_comb begin
        blk_data_s = idle_block();
        case (kind_s)
            K_START: blk_data_s = start_block(seq_r);
            K_DATA:  blk_data_s = fifo_rdata;
            K_TERM:  blk_data_s = term_block(cnt_r, seq_r);
            K_IDLE:  blk_data_s = idle_block();
            default: blk_data_s = idle_block();
        endcase
    end

    // FSM state and burst counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            seq_r   <= 8'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            seq_r   <= seq_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered block output; header and payload hold across stalled slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid_r <= 1'b0;
            tx_hdr_r   <= HDR_CTRL;
            tx_data_r  <= idle_block();
            busy_r     <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            if (tx_ready) begin
                tx_valid_r <= 1'b1;
                tx_hdr_r   <= (kind_s == K_DATA) ? HDR_DATA : HDR_CTRL;
                tx_data_r  <= blk_data_s;
            end else begin
                tx_valid_r <= 1'b0;
                tx_hdr_r   <= tx_hdr_r;
                tx_data_r  <= tx_data_r;
            end
        end
    end

    assign fifo_rd  = fifo_rd_s & ~reset;
    assign tx_valid = tx_valid_r;
    assign tx_hdr   = tx_hdr_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_edm_tx_framer.sv
// tb_edm_tx_framer: randomized scoreboard bench; FIFO contents are split into bursts by a queue model.
module tb_edm_tx_framer;

    localparam int MAXB = 4;
    localparam int IPG  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [63:0] fifo_rdata = 64'h0;
    logic        fifo_rd;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [1:0]  tx_hdr;
    logic [63:0] tx_data;
    logic        busy;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic        free;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] fifo_q[$];
    logic [7:0]  model_seq = 8'd0;
    int          ready_mode = 0;
    int          checks = 0;
    int          errors = 0;
    int          idle_rx = 0;
    int          rd_count = 0;
    logic        rd_seen = 1'b0;
    logic        rst_prev = 1'b1;
    logic        prev_ready = 1'b0;
    logic [65:0] prev_blk = 66'h0;

    edm_tx_framer #(.MAX_BURST(MAXB), .IPG_BLOCKS(IPG)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd   (fifo_rd),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_hdr    (tx_hdr),
        .tx_data   (tx_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] start_blk(input logic [7:0] seq);
        return {48'h0, seq, 8'h78};
    endfunction

    function automatic logic [63:0] term_blk(input logic [7:0] cnt, input logic [7:0] seq);
        return {40'h0, seq, cnt, 8'h87};
    endfunction

    function automatic void push_exp(input logic [1:0] hdr, input logic [63:0] data, input logic free);
        exp_t e;
        e.hdr  = hdr;
        e.data = data;
        e.free = free;
        exp_q.push_back(e);
    endfunction

    function automatic void update_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? 64'h0 : fifo_q[0];
    endfunction

    // Reference: queued words are cut into bursts of at most MAXB, each framed START..TERM
    task automatic expect_words(input logic [63:0] words[$]);
        int idx = 0;
        int len;
        bit first = 1'b1;
        while (idx < words.size()) begin
            len = words.size() - idx;
            if (len > MAXB) len = MAXB;
`ifdef EDM_TX_IPG_EN
            if (!first) begin
                for (int g = 0; g < IPG; g++) push_exp(2'b10, 64'h1E, 1'b0);
            end
`endif
            push_exp(2'b10, start_blk(model_seq), first);
            for (int k = 0; k < len; k++) push_exp(2'b01, words[idx + k], 1'b0);
            push_exp(2'b10, term_blk(8'(len), model_seq), 1'b0);
            model_seq = model_seq + 8'd1;
            idx += len;
            first = 1'b0;
        end
    endtask

    task automatic load_txn(input int n);
        logic [63:0] words[$];
        for (int i = 0; i < n; i++) begin
            words.push_back({$urandom, $urandom});
            fifo_q.push_back(words[i]);
        end
        expect_words(words);
        update_fifo();
    endtask

    task automatic step();
        logic [63:0] discard;
        @(posedge clk);
        #1;
        if (rd_seen) begin
            if (fifo_q.size() > 0) begin
                discard = fifo_q.pop_front();
            end else begin
                checks++;
                errors++;
                $display("FAIL pop_empty actual=1 required=0");
            end
        end
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
        update_fifo();
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((fifo_q.size() == 0) && (exp_q.size() == 0) && !busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check("drain", done, 1);
    endtask

    // Monitor: per-slot protocol checks and scoreboard compare on every valid block
    initial begin : monitor
        exp_t e;
        logic is_idle;
        forever begin
            @(negedge clk);
            rd_seen = fifo_rd;
            if (reset) begin
                rst_prev = 1'b1;
            end else begin
                if (fifo_rd) begin
                    rd_count++;
                    check("rd_gate", {tx_ready, fifo_empty}, 2'b10);
                end
                if (!rst_prev) begin
                    check("tx_valid", tx_valid, prev_ready);
                    if (!prev_ready) check("hold", {tx_hdr, tx_data}, prev_blk);
                end
                if (tx_valid) begin
                    is_idle = (tx_hdr == 2'b10) && (tx_data == 64'h1E);
                    if (is_idle && ((exp_q.size() == 0) || exp_q[0].free)) begin
                        idle_rx++;
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block actual=%0h_%0h required=none", tx_hdr, tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("block", {tx_hdr, tx_data}, {e.hdr, e.data});
                    end
                end
                rst_prev = 1'b0;
            end
            prev_ready = tx_ready;
            prev_blk   = {tx_hdr, tx_data};
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [63:0] words[$];
        update_fifo();
        ready_mode = 0;
        repeat (3) step();
        check("reset_state", {tx_valid, busy, fifo_rd, tx_hdr, tx_data}, {1'b0, 1'b0, 1'b0, 2'b10, 64'h1E});
        #2 reset = 1'b0;

        // Empty FIFO: IDLE blocks only
        idle_rx = 0;
        repeat (10) step();
        @(negedge clk);
        #1;
        check("idle_count", idle_rx, 10);

        rd_count = 0;
        load_txn(3);
        wait_drain();
        check("rd_count_3", rd_count, 3);

        rd_count = 0;
        load_txn(6);
        wait_drain();
        check("rd_count_6", rd_count, 6);

        ready_mode = 1;
        rd_count = 0;
        load_txn(3);
        wait_drain();
        check("rd_count_toggle", rd_count, 3);

        ready_mode = 2;
        repeat (25) begin
            load_txn($urandom_range(1, 13));
            wait_drain();
        end

        // Reset two slots after START, mid-burst
        ready_mode = 0;
        tx_ready = 1'b1;
        words.delete();
        for (int i = 0; i < 5; i++) begin
            words.push_back({$urandom, $urandom});
            fifo_q.push_back(words[i]);
        end
        push_exp(2'b10, start_blk(model_seq), 1'b1);
        push_exp(2'b01, words[0], 1'b0);
        push_exp(2'b01, words[1], 1'b0);
        update_fifo();
        step();
        step();
        step();
        check("pre_reset_progress", exp_q.size(), 1);
        check("busy_in_burst", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("reset_async", {tx_valid, busy, fifo_rd, tx_hdr, tx_data}, {1'b0, 1'b0, 1'b0, 2'b10, 64'h1E});
        exp_q.delete();
        model_seq = 8'd0;
        step();
        step();
        check("words_left", fifo_q.size(), 3);
        words = fifo_q;
        expect_words(words);
        #2 reset = 1'b0;
        wait_drain();

        // Single-word bursts across the sequence-number wrap
        repeat (257) begin
            load_txn(1);
            wait_drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edm_tx_framer.md
Name: edm_tx_framer

Overview:
- Downstream consumer of the 64-bit memory-traffic FIFO. It drains words from the FIFO and emits a continuous 66-bit-style block stream to the PHY TX path.
- Each burst of FIFO words is wrapped as START control block, then data blocks, then TERM control block. IDLE control blocks fill every PHY slot that carries no burst traffic.
- Provides burst framing, a per-burst sequence number and a word count, so the RX side can delimit and check memory messages.

Parameters:
- MAX_BURST, 16, maximum data blocks per burst; legal range 1..255.
- IPG_BLOCKS, 2, minimum IDLE blocks between TERM and the next START. Used only with EDM_TX_IPG_EN; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_rdata  in  64  FIFO head word; fall-through, valid whenever fifo_empty=0
- fifo_rd  out  1  combinational pop; FIFO advances at the next clk edge
- tx_ready  in  1  PHY slot strobe; one block is consumed per cycle with tx_ready=1
- tx_valid  out  1  registered; high for one cycle per emitted block
- tx_hdr  out  2  registered sync header: 2'b01 data, 2'b10 control
- tx_data  out  64  registered block payload
- busy  out  1  registered; high while state is START-issued, DATA or TERM

Behaviour:
- Reset (async) values:
  - state=IDLE; seq=0; cnt=0.
  - tx_valid=0, tx_hdr=2'b10, tx_data=64'h1E (IDLE block), busy=0.
  - fifo_rd=0 for as long as reset is high.
- Latency: the block chosen in a tx_ready cycle appears on tx_* at the next edge, with tx_valid=1 for exactly that one cycle.
- tx_ready=0 cycle:
  - tx_valid<=0; tx_hdr and tx_data hold their values.
  - FSM, counters and fifo_rd are all frozen; fifo_rd=0.
- Control block layout (tx_hdr=2'b10):
  - IDLE: [7:0]=8'h1E, rest 0.
  - START: [7:0]=8'h78, [15:8]=seq, rest 0.
  - TERM: [7:0]=8'h87, [15:8]=cnt (data blocks in this burst), [23:16]=seq, rest 0.
- Data block: tx_hdr=2'b01, tx_data=fifo_rdata sampled in the pop cycle.
- fifo_rd = tx_ready & ~fifo_empty & (state==DATA) & (cnt<MAX_BURST). It is never asserted in any other state.
- FSM transitions, evaluated only when tx_ready=1:
  - IDLE:
    - fifo_empty=0: emit START, cnt<=0, go DATA.
    - Otherwise: emit IDLE.
  - DATA:
    - fifo_empty=0 and cnt<MAX_BURST: emit data, pop, cnt<=cnt+1. If cnt+1==MAX_BURST, go TERM.
    - fifo_empty=1: emit TERM carrying the current cnt (0 is legal), seq<=seq+1, go IDLE. No gap block is inserted.
  - TERM: emit TERM with cnt=MAX_BURST, seq<=seq+1, go IDLE.
- seq is 8-bit and wraps 255->0. cnt is 8-bit; MAX_BURST<=255, so cnt never overflows.
- Back-to-back bursts: without the optional feature, START may directly follow TERM when the FIFO is non-empty. Minimum spacing is therefore TERM, START with zero IDLE blocks.
- A word that arrives in the FIFO during a TERM cycle is not popped. It starts the next burst.
- Reset mid-burst:
  - The burst is abandoned with no TERM emitted.
  - Any word already popped is not re-sent.
  - Output returns to IDLE/seq=0 immediately, asynchronously.

Optional Feature:
- Macro EDM_TX_IPG_EN.
- Defined:
  - A 4-bit ipg counter is loaded with IPG_BLOCKS when TERM is emitted, and decrements on each IDLE block emitted in a tx_ready cycle.
  - IDLE->START is allowed only when ipg==0.
  - busy stays high until ipg==0.
  - Reset clears ipg to 0.
- Undefined:
  - No counter is built and IDLE->START depends only on fifo_empty.
  - busy drops as soon as the state returns to IDLE.

Test Plan:
- Reset, tx_ready=1, FIFO empty for 10 cycles -> 10 IDLE blocks (hdr 2'b10, data 64'h1E), fifo_rd never asserted.
- Preload 3 words A,B,C, tx_ready=1 -> START(seq 0), A, B, C, TERM(cnt 3, seq 0), then IDLE. fifo_rd high for exactly 3 cycles.
- MAX_BURST=4, preload 6 words -> START(seq 0), 4 data, TERM(cnt 4, seq 0), START(seq 1), 2 data, TERM(cnt 2, seq 1). With EDM_TX_IPG_EN and IPG_BLOCKS=2, exactly 2 IDLE blocks appear between the first TERM and the second START.
- Preload 3 words, tx_ready toggling 1,0,1,0 -> same block sequence as the contiguous case; tx_valid=0 and no pop on every tx_ready=0 cycle; tx_data held.
- Run 256 single-word bursts -> TERM seq fields count 0..255, then the 257th burst carries seq 0.
- Assert reset two cycles after START mid-burst -> tx_* returns to IDLE block in the same cycle, busy=0, next burst starts with seq 0.
